// File: rtl/value_tx.sv
// Serial transmitter for a 4-bit value: start, 4 data bits LSB first,
// even parity, stop. Requests arriving mid-frame are queued (latest wins).
module value_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit AUTO_SEND    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    shift_q, shift_d;
    logic [3:0]    last_q, last_d;
    logic          pend_q, pend_d;
    logic [3:0]    pend_data_q, pend_data_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [1:0]    idx_q, idx_d;

    logic       req;
    logic       bit_end;
    logic [1:0] idx_nxt;
    logic [3:0] start_val;

    assign req       = send | (AUTO_SEND && (data_in != last_q));
    assign bit_end   = (baud_q == BAUD_MAX);
    assign idx_nxt   = idx_q + 2'd1;
    // A fresh request beats an older queued value.
    assign start_val = req ? data_in : pend_data_q;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        shift_d     = shift_q;
        last_d      = last_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        idx_d       = idx_q;
        baud_d      = '0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (req) begin
                pend_d      = 1'b1;
                pend_data_d = data_in;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (req || pend_q) begin
                    shift_d = start_val;
                    last_d  = start_val;
                    pend_d  = 1'b0;
                    idx_d   = 2'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    idx_d   = 2'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    idx_d = idx_nxt;
                    if (idx_nxt == 2'd0) begin
                        state_d = PARITY;
                        tx_d    = ^shift_q;
                    end else begin
                        tx_d = shift_q[idx_nxt];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shift_q     <= '0;
            last_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            baud_q      <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/value_tx.md
VALUE_TX -- requirements
Module: value_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter AUTO_SEND, default 1: 1 = a change of data_in also requests a frame; 0 = only send requests a frame.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, 4 bits: value to transmit; driven by the upstream 3-slot value register output.
REQ-006 The block SHALL have port send, input, 1 bit: transmit request, a synchronous one-cycle pulse already conditioned upstream.
REQ-007 The block SHALL have port tx, output, 1 bit: registered serial line; idles high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-010 Frame SHALL be 7 bits, in this order: start (0), data_in[0], data_in[1], data_in[2], data_in[3], even parity (XOR of the 4 data bits), stop (1).
REQ-011 FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-012 A request SHALL be send==1, or (AUTO_SEND==1 and data_in != last_sent), where last_sent is a 4-bit register of the last value accepted for transmission.
REQ-013 In IDLE, a request sampled at edge N SHALL cause all of the following at edge N: data_in latched into shift register and last_sent, state set to START, tx driven 0, busy driven 1.
REQ-014 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter reloaded at every bit boundary.
REQ-015 In DATA, a 2-bit index SHALL select the data bits LSB first, and the state SHALL advance to PARITY after the index wraps 3 -> 0.
REQ-016 A frame SHALL occupy exactly 7*CLKS_PER_BIT cycles from the first tx=0 cycle to the last stop-bit cycle inclusive.
REQ-017 At the end of STOP the state SHALL return to IDLE, busy SHALL fall and done SHALL pulse high for exactly one cycle; tx SHALL stay 1.
REQ-018 A request arriving while busy SHALL set a pending flag and capture data_in into a pending register; a later request while busy SHALL overwrite the captured value (latest wins).
REQ-019 With pending set, the cycle after done SHALL start the next frame from the pending value using the REQ-013 timing, clear pending and update last_sent; the bus is therefore idle for exactly 1 cycle between frames.
REQ-020 A request coinciding with the done cycle SHALL be treated as a pending request and take priority over any older pending value.
REQ-021 When AUTO_SEND==1 and send pulses while data_in == last_sent, exactly one frame SHALL be produced, not two.
REQ-022 data_in changes during a frame SHALL NOT alter the bits currently on the line.
REQ-023 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL NOT overflow; the bit index SHALL wrap modulo 4.

Reset
REQ-024 While rst_n==0, all of the following SHALL hold: tx=1, busy=0, done=0, state=IDLE, pending=0, last_sent=4'b0000, all counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously), and no done pulse SHALL follow.
REQ-026 After rst_n rises, with AUTO_SEND==1 and data_in != 0, a frame SHALL start on the first clock edge.

Verification
REQ-027 CLKS_PER_BIT=4, AUTO_SEND=0, data_in=4'b1011, single send pulse -> tx = 0,1,1,0,1,1,1, each bit for 4 cycles; busy high for 28 cycles; one done pulse.
REQ-028 AUTO_SEND=1, data_in stepped 0 -> 5 once -> exactly one frame with data bits 1,0,1,0 and parity 0; no further frames while data_in stays 5.
REQ-029 Start a frame of 4'h3, then send with data_in=4'h6 and send with data_in=4'h9 while busy -> the second frame carries 4'h9, and exactly 1 idle cycle separates the frames.
REQ-030 Request in the exact cycle done is high -> next frame starts on the following cycle with the new value.
REQ-031 Reset pulled low at bit 3 of a frame -> tx=1, busy=0 immediately; no done pulse; normal framing after release.
REQ-032 send pulse together with a data_in change (AUTO_SEND=1) -> exactly one frame.
